// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases NUM_STAGES active-low resets in order, HOLD_CYCLES apart,
// and re-asserts all of them on a software request. Optional macro: RST_SEQ_RDY_EN.
module rst_seq_ctrl #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SW_RST_REQ,
`ifdef RST_SEQ_RDY_EN
  input  logic [NUM_STAGES-1:0] STAGE_RDY,
`endif
  output logic [NUM_STAGES-1:0] STAGE_RST_N,
  output logic                  SEQ_DONE,
  output logic                  SW_RST_ACK
);

  localparam int unsigned IDX_W = $clog2(NUM_STAGES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_GAP,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_rst_n_q, stage_rst_n_d;
  logic                  seq_done_q, seq_done_d;
  logic                  sw_rst_ack_q, sw_rst_ack_d;
  logic                  req_prev_q, req_prev_d;
  logic                  release_ok;

`ifdef RST_SEQ_RDY_EN
  // Bit 0 stands in for "stage 0 never waits"; bit k+1 is STAGE_RDY[k].
  logic [NUM_STAGES:0] rdy_ext;

  always_comb begin
    rdy_ext    = {STAGE_RDY, 1'b1};
    release_ok = rdy_ext[idx_q];
  end
`else
  always_comb begin
    release_ok = 1'b1;
  end
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    stage_rst_n_d = stage_rst_n_q;
    seq_done_d    = seq_done_q;
    sw_rst_ack_d  = 1'b0;
    req_prev_d    = SW_RST_REQ;

    if (SW_RST_REQ) begin
      state_d       = ST_ASSERT;
      cnt_d         = '0;
      idx_d         = '0;
      stage_rst_n_d = '0;
      seq_done_d    = 1'b0;
      sw_rst_ack_d  = ~req_prev_q;
    end else begin
      unique case (state_q)
        ST_ASSERT, ST_GAP: begin
          if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end else if (release_ok) begin
            // cnt saturates at CNT_LAST while a ready handshake holds the release
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
              if (IDX_W'(i) == idx_q) stage_rst_n_d[i] = 1'b1;
            end
            idx_d = idx_q + IDX_W'(1);
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d    = ST_DONE;
              seq_done_d = 1'b1;
            end else begin
              state_d = ST_GAP;
            end
          end
        end
        ST_DONE: begin
        end
        default: begin
          state_d = ST_ASSERT;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_ASSERT;
      cnt_q         <= '0;
      idx_q         <= '0;
      stage_rst_n_q <= '0;
      seq_done_q    <= 1'b0;
      sw_rst_ack_q  <= 1'b0;
      req_prev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      stage_rst_n_q <= stage_rst_n_d;
      seq_done_q    <= seq_done_d;
      sw_rst_ack_q  <= sw_rst_ack_d;
      req_prev_q    <= req_prev_d;
    end
  end

  assign STAGE_RST_N = stage_rst_n_q;
  assign SEQ_DONE    = seq_done_q;
  assign SW_RST_ACK  = sw_rst_ack_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: a 4-stage/hold-4 instance and a 3-stage/hold-1 instance.
module tb_rst_seq_ctrl;

  logic       clk;
  logic       rst_a, req_a;
  logic [3:0] stage_a;
  logic       done_a, ack_a;
  logic       rst_b, req_b;
  logic [2:0] stage_b;
  logic       done_b, ack_b;
`ifdef RST_SEQ_RDY_EN
  logic [3:0] rdy_a;
  logic [2:0] rdy_b;
`endif

  int unsigned n_checks;
  int unsigned n_errors;

  rst_seq_ctrl #(.NUM_STAGES(4), .HOLD_CYCLES(4), .CNT_WIDTH(8)) u_dut_a (
    .CLK         (clk),
    .RST         (rst_a),
    .SW_RST_REQ  (req_a),
`ifdef RST_SEQ_RDY_EN
    .STAGE_RDY   (rdy_a),
`endif
    .STAGE_RST_N (stage_a),
    .SEQ_DONE    (done_a),
    .SW_RST_ACK  (ack_a)
  );

  rst_seq_ctrl #(.NUM_STAGES(3), .HOLD_CYCLES(1), .CNT_WIDTH(4)) u_dut_b (
    .CLK         (clk),
    .RST         (rst_b),
    .SW_RST_REQ  (req_b),
`ifdef RST_SEQ_RDY_EN
    .STAGE_RDY   (rdy_b),
`endif
    .STAGE_RST_N (stage_b),
    .SEQ_DONE    (done_b),
    .SW_RST_ACK  (ack_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [3:0] s, input logic d, input logic k);
    check({tag, ".stage"}, 32'(stage_a), 32'(s));
    check({tag, ".done"},  32'(done_a),  32'(d));
    check({tag, ".ack"},   32'(ack_a),   32'(k));
  endtask

  // Expected stage vector after e edges of uninterrupted gap-timed sequencing (hold 4).
  function automatic logic [3:0] exp_seq(input int unsigned e);
    int unsigned n;
    n = (e / 4 > 4) ? 4 : e / 4;
    return 4'((1 << n) - 1);
  endfunction

  task automatic run_a(input string tag, input int unsigned edges);
    for (int unsigned e = 1; e <= edges; e++) begin
      tick();
      chk_a($sformatf("%s.e%0d", tag, e), exp_seq(e), (e >= 16), 1'b0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_a = 1'b1; req_a = 1'b0;
    rst_b = 1'b1; req_b = 1'b0;
`ifdef RST_SEQ_RDY_EN
    rdy_a = '1;
    rdy_b = '1;
`endif

    // Power-on reset, then the full release sequence.
    repeat (3) tick();
    chk_a("reset", 4'b0000, 1'b0, 1'b0);
    rst_a = 1'b0;
    run_a("seq", 18);

    // Software request held 5 cycles after completion: one ACK pulse only.
    req_a = 1'b1;
    tick();
    chk_a("swreq.first", 4'b0000, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      chk_a($sformatf("swreq.hold%0d", i), 4'b0000, 1'b0, 1'b0);
    end
    req_a = 1'b0;
    run_a("swrel", 16);

    // Request pulse on edge 9 with stages 0,1 released.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    run_a("mid", 8);
    req_a = 1'b1;
    tick();
    chk_a("mid.req", 4'b0000, 1'b0, 1'b1);
    req_a = 1'b0;
    run_a("mid.restart", 16);

    // RST and request together on edge 6: RST wins, no ACK.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    run_a("both.pre", 5);
    rst_a = 1'b1; req_a = 1'b1;
    tick();
    chk_a("both.rst", 4'b0000, 1'b0, 1'b0);
    // Request still high once RST drops; previous-value flop was cleared by RST.
    rst_a = 1'b0;
    tick();
    chk_a("both.after", 4'b0000, 1'b0, 1'b1);
    req_a = 1'b0;
    run_a("both.rel", 4);

    // HOLD_CYCLES=1: one stage per edge.
    tick();
    check("b.reset.stage", 32'(stage_b), 32'(3'b000));
    check("b.reset.done",  32'(done_b),  32'(1'b0));
    rst_b = 1'b0;
    tick();
    check("b.e1.stage", 32'(stage_b), 32'(3'b001));
    check("b.e1.done",  32'(done_b),  32'(1'b0));
    tick();
    check("b.e2.stage", 32'(stage_b), 32'(3'b011));
    check("b.e2.done",  32'(done_b),  32'(1'b0));
    tick();
    check("b.e3.stage", 32'(stage_b), 32'(3'b111));
    check("b.e3.done",  32'(done_b),  32'(1'b1));
    check("b.e3.ack",   32'(ack_b),   32'(1'b0));

`ifdef RST_SEQ_RDY_EN
    // STAGE_RDY[0] low until edge 20 stalls stage 1.
    rst_a = 1'b1; rdy_a = 4'b1110;
    tick();
    rst_a = 1'b0;
    for (int unsigned e = 1; e <= 30; e++) begin
      if (e == 20) rdy_a = 4'b1111;
      tick();
      chk_a($sformatf("rdy.e%0d", e),
            (e < 4) ? 4'b0000 : (e < 20) ? 4'b0001 : (e < 24) ? 4'b0011 :
            (e < 28) ? 4'b0111 : 4'b1111,
            (e >= 28), 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset sequencer that sits downstream of the per-domain reset synchronizers. It releases a set of block-level active-low resets one stage at a time, in a fixed order, with a programmable hold gap between stages. It also re-asserts all stages on a software reset request and acknowledges that request. The controller runs in a single clock domain and drives the reset inputs of the datapath blocks in that domain.

## Interface
- NUM_STAGES, 4, number of sequenced reset outputs (1..16); stage 0 is released first.
- HOLD_CYCLES, 16, cycles between the start of a sequence and stage 0 release, and between consecutive stage releases (>=1).
- CNT_WIDTH, 8, gap counter width; must satisfy 2^CNT_WIDTH > HOLD_CYCLES-1.
- CLK  input  1  single clock; all logic on posedge CLK.
- RST  input  1  reset, synchronous, active-high.
- SW_RST_REQ  input  1  level software reset request, sampled each edge.
- STAGE_RDY  input  NUM_STAGES  per-stage ready; present only with RST_SEQ_RDY_EN.
- STAGE_RST_N  output  NUM_STAGES  active-low stage resets (0 = held in reset).
- SEQ_DONE  output  1  high when every stage is released.
- SW_RST_ACK  output  1  one-cycle pulse accepting SW_RST_REQ.

## Operation
- Registers:
  - state: ASSERT, GAP, DONE.
  - idx: next stage to release, width clog2(NUM_STAGES+1).
  - cnt: CNT_WIDTH bits.
- RST high at an edge:
  - state=ASSERT, cnt=0, idx=0.
  - STAGE_RST_N=all 0, SEQ_DONE=0, SW_RST_ACK=0.
  - RST overrides everything, including mid-sequence.
- SW_RST_REQ high at an edge with RST low, in any state:
  - STAGE_RST_N=all 0, SEQ_DONE=0, SW_RST_ACK=1.
  - state=ASSERT, cnt=0, idx=0.
  - If the request stays high, ASSERT is held with cnt=0. SW_RST_ACK pulses only on the edge where the request is first seen high (rising-edge detect on the registered previous value). The previous-value register resets to 0.
- Otherwise SW_RST_ACK=0, and:
  - ASSERT/GAP, cnt<HOLD_CYCLES-1: cnt+1.
  - ASSERT/GAP, cnt==HOLD_CYCLES-1 and release allowed:
    - STAGE_RST_N[idx]=1, idx+1, cnt=0.
    - If idx was NUM_STAGES-1: state=DONE and SEQ_DONE=1 on the same edge; otherwise state=GAP.
  - DONE: hold all outputs; cnt is don't-care.
- Released stages stay released until RST or SW_RST_REQ. The release order is never reversed or skipped.
- Release is allowed unconditionally unless RST_SEQ_RDY_EN is defined (see Configuration).

## Timing
- Reset values: STAGE_RST_N=0, SEQ_DONE=0, SW_RST_ACK=0.
- Stage 0 releases on the HOLD_CYCLES-th edge after the first edge with RST low and SW_RST_REQ low.
- Stage k releases exactly HOLD_CYCLES edges after stage k-1, when not stalled.
- Total latency, no stalls: NUM_STAGES*HOLD_CYCLES edges.
- HOLD_CYCLES=1 releases one stage per edge.
- All outputs are registered; there are no combinational paths from inputs.
- Simultaneous RST and SW_RST_REQ: RST wins and no ACK is produced.

## Configuration
- RST_SEQ_RDY_EN defined:
  - STAGE_RDY port exists.
  - Release of stage k>=1 additionally requires STAGE_RDY[k-1]==1 at the release edge. Stage 0 never waits.
  - While waiting, cnt saturates at HOLD_CYCLES-1 and the release occurs on the first edge where STAGE_RDY[k-1]==1.
- Not defined:
  - STAGE_RDY port is absent.
  - Releases are purely gap-timed.

## Test plan
- NUM_STAGES=4, HOLD_CYCLES=4; RST high 3 cycles, then low -> STAGE_RST_N steps 0001, 0011, 0111, 1111 on edges 4, 8, 12, 16 after RST low; SEQ_DONE rises on edge 16.
- After SEQ_DONE, SW_RST_REQ high for 5 cycles -> next edge STAGE_RST_N=0000, SEQ_DONE=0, single SW_RST_ACK pulse; stage 0 releases 4 edges after REQ drops.
- SW_RST_REQ pulse at edge 9 mid-sequence (stages 0,1 released) -> all stages reasserted, ACK=1, sequence restarts from stage 0.
- RST high at edge 6 with SW_RST_REQ also high -> outputs at reset values, SW_RST_ACK stays 0.
- HOLD_CYCLES=1, NUM_STAGES=3 -> stages released on consecutive edges 1, 2, 3; SEQ_DONE on edge 3.
- With RST_SEQ_RDY_EN, STAGE_RDY[0] held low until edge 20 -> stage 1 releases on edge 20 rather than 8; subsequent stages at 24 and 28.
